// File: rtl/spi_slave_responder_if.sv
// Host-side parallel bus of the SPI responder: TX/RX holding-register access,
// flag clearing and the STATUS byte.
interface spi_slave_responder_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  WRITE;
    logic [DATA_WIDTH-1:0] INCOMING_DATA;
    logic                  READ;
    logic [DATA_WIDTH-1:0] OUTCOMING_DATA;
    logic                  CLR_FLAGS;
    logic [7:0]            STATUS;

    modport slave (
        input  WRITE, INCOMING_DATA, READ, CLR_FLAGS,
        output OUTCOMING_DATA, STATUS
    );

    modport master (
        output WRITE, INCOMING_DATA, READ, CLR_FLAGS,
        input  OUTCOMING_DATA, STATUS
    );
endinterface

// File: rtl/spi_slave_responder.sv
// SPI mode-0 responder with oversampled serial pins, one-byte TX/RX holding
// registers and sticky error flags reported through a STATUS byte.
module spi_slave_responder #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] IDLE_BYTE   = {DATA_WIDTH{1'b0}}
) (
    input  logic                    CLK,
    input  logic                    CLR,
    spi_slave_responder_if.slave    host,
    input  logic                    S_CLK,
    input  logic                    CS,
    input  logic                    IN,
    output logic                    OUT
);
    localparam int                 CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_r;
    logic [SYNC_STAGES-1:0] cs_sync_r;
    logic [SYNC_STAGES-1:0] in_sync_r;
    logic                   sclk_dly_r;
    logic                   cs_dly_r;

    state_t                 state_r;
    logic [CNT_W-1:0]       bit_cnt_r;
    logic                   reload_pend_r;
    logic [DATA_WIDTH-1:0]  tx_shift_r;
    logic [DATA_WIDTH-2:0]  rx_shift_r;
    logic [DATA_WIDTH-1:0]  tx_hold_r;
    logic [DATA_WIDTH-1:0]  rx_hold_r;
    logic                   tx_empty_r;
    logic                   rx_full_r;
    logic                   overrun_r;
    logic                   frame_err_r;
    logic                   underrun_r;
    logic                   wcol_r;
    logic                   busy_r;
    logic                   out_en_r;

    logic                   sclk_rise_s;
    logic                   sclk_fall_s;
    logic                   cs_rise_s;
    logic                   cs_fall_s;
    logic                   in_s;
    logic [DATA_WIDTH-1:0]  rx_byte_s;
    logic [DATA_WIDTH-1:0]  tx_next_s;
    logic                   tx_load_s;
    logic                   rx_done_s;
    logic                   cs_end_s;
    logic                   take_s;
    logic                   wr_ok_s;
    logic                   wcol_s;
    logic                   rx_room_s;

    // Oversample the serial pins; CS idles high so reset must not fake a falling edge.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            sclk_sync_r <= {SYNC_STAGES{1'b0}};
            cs_sync_r   <= {SYNC_STAGES{1'b1}};
            in_sync_r   <= {SYNC_STAGES{1'b0}};
            sclk_dly_r  <= 1'b0;
            cs_dly_r    <= 1'b1;
        end else begin
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], S_CLK};
            cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], CS};
            in_sync_r   <= {in_sync_r[SYNC_STAGES-2:0], IN};
            sclk_dly_r  <= sclk_sync_r[SYNC_STAGES-1];
            cs_dly_r    <= cs_sync_r[SYNC_STAGES-1];
        end
    end

    assign sclk_rise_s = sclk_sync_r[SYNC_STAGES-1] & ~sclk_dly_r;
    assign sclk_fall_s = ~sclk_sync_r[SYNC_STAGES-1] & sclk_dly_r;
    assign cs_rise_s   = cs_sync_r[SYNC_STAGES-1] & ~cs_dly_r;
    assign cs_fall_s   = ~cs_sync_r[SYNC_STAGES-1] & cs_dly_r;
    assign in_s        = in_sync_r[SYNC_STAGES-1];
    assign rx_byte_s   = {rx_shift_r, in_s};
    assign tx_next_s   = tx_empty_r ? IDLE_BYTE : tx_hold_r;

    // Decode the serial events of this cycle; CS release outranks any coincident clock edge.
    always_comb begin
        tx_load_s = 1'b0;
        rx_done_s = 1'b0;
        cs_end_s  = 1'b0;
        case (state_r)
            ST_LOAD: tx_load_s = 1'b1;
            ST_SHIFT: begin
                if (cs_rise_s) begin
                    cs_end_s = 1'b1;
                end else if (sclk_rise_s && (bit_cnt_r == CNT_LAST)) begin
                    rx_done_s = 1'b1;
                end else if (sclk_fall_s && (bit_cnt_r == CNT_ZERO) && reload_pend_r) begin
                    tx_load_s = 1'b1;
                end else begin
                    tx_load_s = 1'b0;
                end
            end
            default: tx_load_s = 1'b0;
        endcase
        take_s    = tx_load_s & ~tx_empty_r;
        wr_ok_s   = host.WRITE & (tx_empty_r | take_s);
        wcol_s    = host.WRITE & ~wr_ok_s;
        rx_room_s = ~rx_full_r | host.READ;
    end

    // Frame FSM with shifters, holding registers and sticky flags.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_r       <= ST_IDLE;
            bit_cnt_r     <= CNT_ZERO;
            reload_pend_r <= 1'b0;
            tx_shift_r    <= {DATA_WIDTH{1'b0}};
            rx_shift_r    <= {(DATA_WIDTH-1){1'b0}};
            tx_hold_r     <= {DATA_WIDTH{1'b0}};
            rx_hold_r     <= {DATA_WIDTH{1'b0}};
            tx_empty_r    <= 1'b1;
            rx_full_r     <= 1'b0;
            overrun_r     <= 1'b0;
            frame_err_r   <= 1'b0;
            underrun_r    <= 1'b0;
            wcol_r        <= 1'b0;
            busy_r        <= 1'b0;
            out_en_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    busy_r   <= 1'b0;
                    out_en_r <= 1'b0;
                    if (cs_fall_s) begin
                        state_r <= ST_LOAD;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    tx_shift_r    <= tx_next_s;
                    bit_cnt_r     <= CNT_ZERO;
                    reload_pend_r <= 1'b0;
                    busy_r        <= ~cs_rise_s;
                    out_en_r      <= ~cs_rise_s;
                    state_r       <= cs_rise_s ? ST_IDLE : ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (cs_rise_s) begin
                        state_r  <= ST_IDLE;
                        busy_r   <= 1'b0;
                        out_en_r <= 1'b0;
                    end else if (sclk_rise_s) begin
                        rx_shift_r <= rx_byte_s[DATA_WIDTH-2:0];
                        if (bit_cnt_r == CNT_LAST) begin
                            bit_cnt_r     <= CNT_ZERO;
                            reload_pend_r <= 1'b1;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + CNT_ONE;
                        end
                    end else if (sclk_fall_s) begin
                        if (bit_cnt_r != CNT_ZERO) begin
                            tx_shift_r <= {tx_shift_r[DATA_WIDTH-2:0], 1'b0};
                        end else if (reload_pend_r) begin
                            tx_shift_r    <= tx_next_s;
                            reload_pend_r <= 1'b0;
                        end else begin
                            tx_shift_r <= tx_shift_r;
                        end
                    end else begin
                        state_r <= ST_SHIFT;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    busy_r   <= 1'b0;
                    out_en_r <= 1'b0;
                end
            endcase

            // A write coincident with consumption lands after the shifter has taken the old byte.
            if (wr_ok_s) begin
                tx_hold_r  <= host.INCOMING_DATA;
                tx_empty_r <= 1'b0;
            end else if (take_s) begin
                tx_empty_r <= 1'b1;
            end else begin
                tx_empty_r <= tx_empty_r;
            end

            if (rx_done_s && rx_room_s) begin
                rx_hold_r <= rx_byte_s;
                rx_full_r <= 1'b1;
            end else if (host.READ) begin
                rx_full_r <= 1'b0;
            end else begin
                rx_full_r <= rx_full_r;
            end

            overrun_r   <= (overrun_r & ~host.CLR_FLAGS) | (rx_done_s & ~rx_room_s);
            frame_err_r <= (frame_err_r & ~host.CLR_FLAGS) | (cs_end_s & (bit_cnt_r != CNT_ZERO));
            underrun_r  <= (underrun_r & ~host.CLR_FLAGS) | (tx_load_s & tx_empty_r);
            wcol_r      <= (wcol_r & ~host.CLR_FLAGS) | wcol_s;
        end
    end

    assign host.STATUS         = {busy_r, 1'b0, wcol_r, underrun_r, frame_err_r,
                                  overrun_r, tx_empty_r, rx_full_r};
    assign host.OUTCOMING_DATA = rx_hold_r;
    assign OUT                 = out_en_r ? tx_shift_r[DATA_WIDTH-1] : 1'bz;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Randomized scoreboard bench for spi_slave_responder: a byte-level reference
// model predicts MISO bytes and end-of-frame STATUS/RX data; monitors compare.
module tb_spi_slave_responder;
    localparam int HALF = 10;

    logic clk;
    logic rst_n;
    logic sclk_pin;
    logic cs_pin;
    logic in_pin;
    wire  out_pin;

    spi_slave_responder_if #(.DATA_WIDTH(8)) bus ();

    spi_slave_responder #(
        .DATA_WIDTH (8),
        .SYNC_STAGES(2),
        .IDLE_BYTE  (8'h00)
    ) dut (
        .CLK  (clk),
        .CLR  (rst_n),
        .host (bus),
        .S_CLK(sclk_pin),
        .CS   (cs_pin),
        .IN   (in_pin),
        .OUT  (out_pin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_en = 1'b0;

    logic [7:0]  exp_miso_q[$];
    logic [7:0]  act_miso_q[$];
    logic [15:0] exp_end_q[$];
    logic [7:0]  exp_mid;

    // reference model state
    logic [7:0] m_tx_hold, m_rx_hold;
    bit m_tx_full, m_rx_full, m_ovr, m_fe, m_und, m_wcol;

    // per-frame stimulus description
    logic [7:0] fr_mosi[4];
    logic [7:0] fr_wd_mid[4];
    logic [7:0] fr_wd_rel[4];
    bit fr_rd_mid[4], fr_wr_mid[4], fr_rd_done[4], fr_wr_rel[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    function automatic logic [7:0] m_status(input bit busy);
        return {busy, 1'b0, m_wcol, m_und, m_fe, m_ovr, ~m_tx_full, m_rx_full};
    endfunction

    task automatic m_reset();
        m_tx_hold = 8'h00; m_rx_hold = 8'h00;
        m_tx_full = 1'b0; m_rx_full = 1'b0;
        m_ovr = 1'b0; m_fe = 1'b0; m_und = 1'b0; m_wcol = 1'b0;
    endtask

    task automatic m_write(input logic [7:0] d);
        if (m_tx_full) m_wcol = 1'b1;
        else begin m_tx_hold = d; m_tx_full = 1'b1; end
    endtask

    task automatic m_consume(output logic [7:0] b);
        if (m_tx_full) begin b = m_tx_hold; m_tx_full = 1'b0; end
        else begin b = 8'h00; m_und = 1'b1; end
    endtask

    // Byte-level prediction of one CS frame: n full bytes then p partial bits.
    task automatic model_frame(input int n, input int p);
        logic [7:0] tx;
        m_consume(tx);
        for (int k = 0; k < n; k++) begin
            exp_miso_q.push_back(tx);
            if (fr_rd_mid[k]) m_rx_full = 1'b0;
            if (fr_wr_mid[k]) m_write(fr_wd_mid[k]);
            if (fr_rd_done[k]) m_rx_full = 1'b0;
            if (m_rx_full) m_ovr = 1'b1;
            else begin m_rx_hold = fr_mosi[k]; m_rx_full = 1'b1; end
            if (k < n - 1 || p > 0) begin
                m_consume(tx);
                if (fr_wr_rel[k]) m_write(fr_wd_rel[k]);
            end else begin
                exp_mid = m_status(1'b1);
            end
        end
        if (p > 0) m_fe = 1'b1;
        exp_end_q.push_back({m_status(1'b0), m_rx_hold});
    endtask

    task automatic clear_frame();
        for (int k = 0; k < 4; k++) begin
            fr_mosi[k] = 8'h00; fr_wd_mid[k] = 8'h00; fr_wd_rel[k] = 8'h00;
            fr_rd_mid[k] = 1'b0; fr_wr_mid[k] = 1'b0; fr_rd_done[k] = 1'b0; fr_wr_rel[k] = 1'b0;
        end
    endtask

    task automatic host(input bit rd, input bit wr, input logic [7:0] d, input bit cf);
        bus.READ = rd; bus.WRITE = wr; bus.INCOMING_DATA = d; bus.CLR_FLAGS = cf;
        cyc(1);
        bus.READ = 1'b0; bus.WRITE = 1'b0; bus.CLR_FLAGS = 1'b0;
        if (cf) begin m_ovr = 1'b0; m_fe = 1'b0; m_und = 1'b0; m_wcol = 1'b0; end
        if (wr) m_write(d);
        if (rd) m_rx_full = 1'b0;
        cyc(1);
        check("host_status", 32'(bus.STATUS), 32'(m_status(1'b0)));
        check("host_rxdata", 32'(bus.OUTCOMING_DATA), 32'(m_rx_hold));
    endtask

    // Mode-0 master; the last falling S_CLK edge and the CS release share one instant.
    task automatic run_frame(input int n, input int p);
        int nbytes, nb;
        logic [7:0] cap, pend_d;
        bit pend_wr, last;
        nbytes = (p > 0) ? n + 1 : n;
        pend_wr = 1'b0; pend_d = 8'h00;
        cs_pin = 1'b0;
        for (int k = 0; k < nbytes; k++) begin
            nb = (k < n) ? 8 : p;
            cap = 8'h00;
            for (int b = 0; b < nb; b++) begin
                in_pin = fr_mosi[k][7-b];
                if (pend_wr) begin
                    cyc(2); bus.INCOMING_DATA = pend_d; bus.WRITE = 1'b1;
                    cyc(1); bus.WRITE = 1'b0; cyc(HALF - 3);
                    pend_wr = 1'b0;
                end else cyc(HALF);
                cap = {cap[6:0], out_pin};
                sclk_pin = 1'b1;
                if (b == 7 && fr_rd_done[k]) begin
                    cyc(2); bus.READ = 1'b1; cyc(1); bus.READ = 1'b0; cyc(HALF - 3);
                end else if (b == 3 && k < n && (fr_rd_mid[k] || fr_wr_mid[k])) begin
                    cyc(5);
                    bus.READ = fr_rd_mid[k]; bus.WRITE = fr_wr_mid[k]; bus.INCOMING_DATA = fr_wd_mid[k];
                    cyc(1); bus.READ = 1'b0; bus.WRITE = 1'b0; cyc(HALF - 6);
                end else cyc(HALF);
                last = (k == nbytes - 1) && (b == nb - 1);
                if (last && p == 0) check("mid_status", 32'(bus.STATUS), 32'(exp_mid));
                sclk_pin = 1'b0;
                if (last) cs_pin = 1'b1;
            end
            if (k < n) begin
                act_miso_q.push_back(cap);
                if (fr_wr_rel[k] && (k < n - 1 || p > 0)) begin pend_wr = 1'b1; pend_d = fr_wd_rel[k]; end
            end
        end
    endtask

    task automatic do_frame(input int n, input int p);
        model_frame(n, p);
        run_frame(n, p);
        cyc(8);
    endtask

    // MISO monitor: every byte the master captured is checked against the model.
    initial begin
        logic [7:0] a, e;
        forever begin
            @(negedge clk);
            while (act_miso_q.size() > 0) begin
                a = act_miso_q.pop_front();
                if (exp_miso_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL miso_unexpected: got %h expected none", a);
                end else begin
                    e = exp_miso_q.pop_front();
                    check("miso_byte", 32'(a), 32'(e));
                end
            end
        end
    end

    // End-of-frame monitor: BUSY falling presents STATUS and the RX hold.
    initial begin
        bit busy_prev;
        logic [15:0] e;
        busy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en && busy_prev && !bus.STATUS[7]) begin
                if (exp_end_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL end_unexpected: got status %h expected none", bus.STATUS);
                end else begin
                    e = exp_end_q.pop_front();
                    check("end_status", 32'(bus.STATUS), 32'(e[15:8]));
                    check("end_rxdata", 32'(bus.OUTCOMING_DATA), 32'(e[7:0]));
                end
            end
            busy_prev = bus.STATUS[7];
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, p;
        bit rd, wr, cf;
        rst_n = 1'b0; sclk_pin = 1'b0; cs_pin = 1'b1; in_pin = 1'b0;
        bus.WRITE = 1'b0; bus.READ = 1'b0; bus.CLR_FLAGS = 1'b0; bus.INCOMING_DATA = 8'h00;
        m_reset();
        clear_frame();
        cyc(3);
        check("reset_status", 32'(bus.STATUS), 32'h02);
        check("reset_rxdata", 32'(bus.OUTCOMING_DATA), 32'h00);
        rst_n = 1'b1;
        cyc(4);
        mon_en = 1'b1;

        // single frame
        host(1'b0, 1'b1, 8'hA5, 1'b0);
        clear_frame(); fr_mosi[0] = 8'h3C;
        do_frame(1, 0);

        // burst of two bytes with mid-frame WRITE and READ
        host(1'b1, 1'b1, 8'h11, 1'b0);
        clear_frame(); fr_mosi[0] = 8'hF0; fr_mosi[1] = 8'h0F;
        fr_wr_mid[0] = 1'b1; fr_wd_mid[0] = 8'h22; fr_rd_mid[1] = 1'b1;
        do_frame(2, 0);

        // overrun and underrun
        host(1'b1, 1'b0, 8'h00, 1'b1);
        clear_frame(); fr_mosi[0] = 8'h55; do_frame(1, 0);
        clear_frame(); fr_mosi[0] = 8'hAA; do_frame(1, 0);

        // frame error, recovery, flag clear
        host(1'b1, 1'b1, 8'h5A, 1'b1);
        clear_frame(); fr_mosi[0] = 8'hB7; do_frame(0, 5);
        clear_frame(); fr_mosi[0] = 8'h81; do_frame(1, 0);
        host(1'b0, 1'b0, 8'h00, 1'b1);

        // write collision, READ coincident with byte completion
        host(1'b0, 1'b1, 8'h01, 1'b0);
        host(1'b0, 1'b1, 8'h02, 1'b0);
        clear_frame(); fr_mosi[0] = 8'h6E; fr_rd_done[0] = 1'b1; do_frame(1, 0);

        // WRITE coincident with TX hold consumption at a byte boundary
        host(1'b1, 1'b1, 8'h3A, 1'b1);
        clear_frame(); fr_mosi[0] = 8'h12; fr_mosi[1] = 8'h34;
        fr_wr_rel[0] = 1'b1; fr_wd_rel[0] = 8'hC5; fr_rd_mid[1] = 1'b1;
        do_frame(2, 0);

        // reset in the middle of a frame
        mon_en = 1'b0;
        cs_pin = 1'b0;
        for (int b = 0; b < 4; b++) begin
            in_pin = 1'($urandom); cyc(HALF); sclk_pin = 1'b1; cyc(HALF); sclk_pin = 1'b0;
        end
        cyc(HALF / 2);
        rst_n = 1'b0;
        #1;
        check("midreset_status", 32'(bus.STATUS), 32'h02);
        check("midreset_rxdata", 32'(bus.OUTCOMING_DATA), 32'h00);
        cyc(1); cs_pin = 1'b1; cyc(3);
        rst_n = 1'b1;
        m_reset();
        cyc(6);
        mon_en = 1'b1;
        host(1'b0, 1'b1, 8'($urandom), 1'b0);
        clear_frame(); fr_mosi[0] = 8'hC3; do_frame(1, 0);

        // randomized frames
        for (int f = 0; f < 40; f++) begin
            clear_frame();
            n = $urandom_range(1, 3);
            p = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 0;
            for (int k = 0; k < 4; k++) begin
                fr_mosi[k]   = 8'($urandom);
                fr_wd_mid[k] = 8'($urandom);
                fr_wd_rel[k] = 8'($urandom);
                if (k < n) begin
                    fr_rd_mid[k]  = ($urandom_range(0, 2) == 0);
                    fr_wr_mid[k]  = ($urandom_range(0, 2) == 0);
                    fr_rd_done[k] = ($urandom_range(0, 4) == 0);
                    fr_wr_rel[k]  = (k < n - 1 || p > 0) && ($urandom_range(0, 3) == 0);
                end
            end
            rd = ($urandom_range(0, 1) == 1);
            wr = ($urandom_range(0, 1) == 1);
            cf = ($urandom_range(0, 3) == 0);
            if (rd || wr || cf) host(rd, wr, 8'($urandom), cf);
            do_frame(n, p);
        end

        cyc(20);
        check("left_exp_end", 32'(exp_end_q.size()), 32'd0);
        check("left_exp_miso", 32'(exp_miso_q.size()), 32'd0);
        check("left_act_miso", 32'(act_miso_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
